// File: rtl/oled_pkg.sv
// Shared constants for the SSD1306 bring-up sequencer: FSM encodings, the
// power-up command list, address-window opcodes and error codes.
package oled_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_INIT = 3'd1;
    localparam state_t ST_WIN  = 3'd2;
    localparam state_t ST_FILL = 3'd3;
    localparam state_t ST_WAIT = 3'd4;
    localparam state_t ST_DONE = 3'd5;
    localparam state_t ST_ERR  = 3'd6;

    localparam int INIT_LEN = 25;
    localparam int WIN_LEN  = 6;

    // Display off, clocking, multiplex, charge pump, horizontal addressing,
    // remap, contrast, precharge, VCOMH, resume-from-RAM, normal, display on.
    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40, 8'h8D,
        8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12, 8'h81, 8'hCF,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF
    };

    localparam logic [7:0] CMD_SET_COL  = 8'h21;
    localparam logic [7:0] CMD_SET_PAGE = 8'h22;

    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    typedef logic [1:0] err_t;

    localparam err_t ERR_NONE    = 2'd0;
    localparam err_t ERR_NACK    = 2'd1;
    localparam err_t ERR_TIMEOUT = 2'd2;

    function automatic logic is_issue(input state_t s);
        return (s == ST_INIT) || (s == ST_WIN) || (s == ST_FILL);
    endfunction

endpackage

// File: rtl/oled_init_rom.sv
// Combinational lookup of the SSD1306 power-up command list; addresses past
// the end of the list read as 0x00.
module oled_init_rom
    import oled_pkg::*;
(
    input  logic [4:0] addr_i,
    output logic [7:0] data_o
);

    always_comb begin
        data_o = 8'h00;
        if (addr_i < 5'(INIT_LEN)) begin
            data_o = INIT_ROM[addr_i];
        end
    end

endmodule

// File: rtl/oled_init_sequencer.sv
// Sequences the SSD1306 bring-up: init command list, full-screen address
// window, then PAGES*COLS fill bytes, one byte per master transaction.
module oled_init_sequencer
    import oled_pkg::*;
#(
    parameter int PAGES     = 8,
    parameter int COLS      = 128,
    parameter int MAX_RETRY = 3,
    parameter int TIMEOUT   = 65535
) (
    input  logic       CLK,
    input  logic       NRST,
    input  logic       start,
    input  logic [7:0] fill_byte,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] err_code,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_dc,
    output logic [7:0] m_byte,
    input  logic       m_done,
    input  logic       m_nack
);

    localparam int NBYTES  = PAGES * COLS;
    localparam int IDX_W   = $clog2(NBYTES);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    localparam logic [IDX_W-1:0]   INIT_LAST = IDX_W'(INIT_LEN - 1);
    localparam logic [IDX_W-1:0]   WIN_LAST  = IDX_W'(WIN_LEN - 1);
    localparam logic [IDX_W-1:0]   FILL_LAST = IDX_W'(NBYTES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
    localparam logic [15:0]        TIMER_MAX = 16'(TIMEOUT);
    localparam logic [7:0]         COL_END   = 8'(COLS - 1);
    localparam logic [7:0]         PAGE_END  = 8'(PAGES - 1);

    state_t               state_q, state_d;
    state_t               phase_q, phase_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [15:0]          timer_q, timer_d;
    logic [7:0]           fill_q, fill_d;
    err_t                 err_q, err_d;

    logic [IDX_W-1:0]     last_idx;
    state_t               next_phase;
    logic [7:0]           rom_byte;
    logic [7:0]           win_byte;

    oled_init_rom u_rom (
        .addr_i (idx_q[4:0]),
        .data_o (rom_byte)
    );

    // The phase remembered across WAIT decides where the byte counter ends
    // and which phase follows it.
    always_comb begin
        last_idx   = FILL_LAST;
        next_phase = ST_DONE;
        case (phase_q)
            ST_INIT: begin
                last_idx   = INIT_LAST;
                next_phase = ST_WIN;
            end
            ST_WIN: begin
                last_idx   = WIN_LAST;
                next_phase = ST_FILL;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (idx_q[2:0])
            3'd0:    win_byte = CMD_SET_COL;
            3'd1:    win_byte = 8'h00;
            3'd2:    win_byte = COL_END;
            3'd3:    win_byte = CMD_SET_PAGE;
            3'd4:    win_byte = 8'h00;
            3'd5:    win_byte = PAGE_END;
            default: win_byte = 8'h00;
        endcase
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case statements can infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        timer_d = timer_q;
        fill_d  = fill_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    fill_d  = fill_byte;
                    idx_d   = '0;
                    retry_d = '0;
                    err_d   = ERR_NONE;
                    state_d = ST_INIT;
                end
            end
            ST_INIT, ST_WIN, ST_FILL: begin
                if (m_ready) begin
                    phase_d = state_q;
                    timer_d = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A NACK wins over a simultaneous done pulse.
                if (m_nack) begin
                    if (retry_q == RETRY_MAX) begin
                        err_d   = ERR_NACK;
                        state_d = ST_ERR;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                        state_d = phase_q;
                    end
                end else if (m_done) begin
                    retry_d = '0;
                    if (idx_q == last_idx) begin
                        idx_d   = '0;
                        state_d = next_phase;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = phase_q;
                    end
                end else if (timer_q == TIMER_MAX) begin
                    err_d   = ERR_TIMEOUT;
                    state_d = ST_ERR;
                end else if (timer_q != 16'hFFFF) begin
                    timer_d = timer_q + 16'd1;
                end
            end
            ST_DONE, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= ST_IDLE;
            phase_q <= ST_INIT;
            idx_q   <= '0;
            retry_q <= '0;
            timer_q <= '0;
            fill_q  <= 8'h00;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

    // Byte/flag are pure functions of state and index, so they cannot move
    // while an offer is waiting for m_ready.
    always_comb begin
        m_valid = 1'b0;
        m_dc    = 1'b0;
        m_byte  = 8'h00;
        case (state_q)
            ST_INIT: begin
                m_valid = 1'b1;
                m_byte  = rom_byte;
            end
            ST_WIN: begin
                m_valid = 1'b1;
                m_byte  = win_byte;
            end
            ST_FILL: begin
                m_valid = 1'b1;
                m_dc    = 1'b1;
                m_byte  = fill_q;
            end
            default: ;
        endcase
    end

    assign busy     = is_issue(state_q) || (state_q == ST_WAIT);
    assign done     = (state_q == ST_DONE);
    assign error    = (state_q == ST_ERR);
    assign err_code = err_q;

endmodule
